stp_sr_8_lsb_rx: RTL



---
 rtl/stp_sr_8_lsb_rx.sv | 104 ++++++++++
 1 files changed

// File: rtl/stp_sr_8_lsb_rx.sv
// Serial receiver: samples d_in on mid-bit strobes, rebuilds LSB-first words, one-entry valid/ready buffer.
// Optional macro STP_OVERRUN_OVERWRITE_EN: on overrun the newest word replaces the buffered one.
module stp_sr_8_lsb_rx #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_in,
  input  logic                strobe,
  input  logic                strobe_middle,
  input  logic                rx_enable,
  input  logic                rx_ready,
  input  logic                err_clear,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                overrun_err,
  output logic                frame_err
);

  localparam int CW = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, RECV} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [NUM_BITS-1:0] shift_reg;
  logic [NUM_BITS-1:0] shift_next;
  logic                sample;
  logic                word_done;
  logic                accept;

  // Shift direction decides whether the first received bit ends up at bit 0 or at the MSB.
  generate
    if (SHIFT_MSB != 0) begin : g_shift_left
      assign shift_next = {shift_reg[NUM_BITS-2:0], d_in};
    end else begin : g_shift_right
      assign shift_next = {d_in, shift_reg[NUM_BITS-1:1]};
    end
  endgenerate

  assign sample    = (state == RECV) && rx_enable && strobe_middle;
  assign word_done = sample && (count == LAST);
  assign accept    = !rx_valid || rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_enable) state <= ALIGN;
        end
        ALIGN: begin
          if (!rx_enable)  state <= IDLE;
          else if (strobe) state <= RECV;
        end
        RECV: begin
          if (!rx_enable) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
          end else if (strobe_middle) begin
            shift_reg <= shift_next;
            count     <= (count == LAST) ? '0 : count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      // Clear is applied first so a same-cycle error event still leaves its flag set.
      if (err_clear) begin
        overrun_err <= 1'b0;
        frame_err   <= 1'b0;
      end

      if ((state == RECV) && !rx_enable && (count != '0)) frame_err <= 1'b1;

      if (word_done) begin
        if (accept) begin
          rx_data  <= shift_next;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
`ifdef STP_OVERRUN_OVERWRITE_EN
          rx_data     <= shift_next;
`else
          rx_data     <= rx_data;
`endif
        end
      end
    end
  end

endmodule
